// File: rtl/setpoint_pkg.sv
// Shared types and command decode for the setpoint controller.
// Imported by the interface, the hold timer and the top level.
package setpoint_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      REPEAT
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_UP,
      CMD_DOWN,
      CMD_PRESET
   } cmd_t;

   localparam int BTN_W = 5;

   // Preset wins; opposing up/down cancel each other out.
   function automatic cmd_t decode_cmd(input logic [BTN_W-1:0] b);
      logic up;
      logic dn;
      cmd_t c;
      up = b[0] | b[3];
      dn = b[1] | b[2];
      c  = CMD_NONE;
      if (b[4])
         c = CMD_PRESET;
      else if (up && dn)
         c = CMD_NONE;
      else if (up)
         c = CMD_UP;
      else if (dn)
         c = CMD_DOWN;
      return c;
   endfunction

endpackage

// File: rtl/setpoint_if.sv
// Button-in / setpoint-out bundle between the debouncer side
// and the seven-segment side.
interface setpoint_if
   import setpoint_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic [BTN_W-1:0] buttons;
   logic [WIDTH-1:0] value;
   logic             changed;
   logic             at_limit;
   logic             holding;

   modport master (
      output buttons,
      input  value,
      input  changed,
      input  at_limit,
      input  holding
   );

   modport slave (
      input  buttons,
      output value,
      output changed,
      output at_limit,
      output holding
   );
endinterface

// File: rtl/setpoint_controller_hold_timer.sv
// Loadable down-counter that stops at zero.
// expired is high whenever the count sits at zero.
module hold_timer #(
   parameter int TW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expired
);

   logic [TW-1:0] cnt_q;

   // Load has priority; otherwise count down and park at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/setpoint_controller.sv
// Turns debounced button levels into saturating setpoint steps,
// one step per press plus auto-repeat while up/down is held.
module setpoint_controller
   import setpoint_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int INIT_VAL      = 22,
   parameter int MIN_VAL       = 0,
   parameter int MAX_VAL       = 99,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input logic      clk,
   input logic      reset,
   setpoint_if.slave sp
);

   localparam int TMAX =
      (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
   localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
   localparam logic [TW-1:0]    HOLD_V = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]    REP_V  = TW'(REPEAT_CYCLES - 1);
   localparam logic INIT_LIM =
      (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);

   state_t state_q, state_d;
   cmd_t   cmd_q, cmd_d;
   cmd_t   cmd;

   logic             step;
   logic             t_load;
   logic [TW-1:0]    t_val;
   logic             t_exp;

   logic [WIDTH-1:0] val_q, val_d;
   logic             chg_q;
   logic             lim_q;

   assign cmd = decode_cmd(sp.buttons);

   hold_timer #(
      .TW (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_val),
      .expired  (t_exp)
   );

   // State and latched command registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cmd_q   <= CMD_NONE;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
      end
   end

   // Next state, step request and timer reload.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      step    = 1'b0;
      t_load  = 1'b0;
      t_val   = '0;
      unique case (state_q)
         IDLE: begin
            if (cmd != CMD_NONE) begin
               step    = 1'b1;
               cmd_d   = cmd;
               t_load  = 1'b1;
               t_val   = HOLD_V;
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (cmd == CMD_NONE) begin
               cmd_d   = CMD_NONE;
               state_d = IDLE;
            end else if (cmd != cmd_q) begin
               step   = 1'b1;
               cmd_d  = cmd;
               t_load = 1'b1;
               t_val  = HOLD_V;
            end else if (t_exp && cmd_q != CMD_PRESET) begin
               step    = 1'b1;
               t_load  = 1'b1;
               t_val   = REP_V;
               state_d = REPEAT;
            end
         end
         REPEAT: begin
            if (cmd == CMD_NONE) begin
               cmd_d   = CMD_NONE;
               state_d = IDLE;
            end else if (cmd != cmd_q) begin
               step    = 1'b1;
               cmd_d   = cmd;
               t_load  = 1'b1;
               t_val   = HOLD_V;
               state_d = PRESS;
            end else if (t_exp) begin
               step   = 1'b1;
               t_load = 1'b1;
               t_val  = REP_V;
            end
         end
         default: begin
            state_d = IDLE;
            cmd_d   = CMD_NONE;
         end
      endcase
   end

   // Saturating step of the setpoint for the current command.
   always_comb begin
      val_d = val_q;
      if (step) begin
         unique case (cmd)
            CMD_UP:     if (val_q < MAX_V) val_d = val_q + 1'b1;
            CMD_DOWN:   if (val_q > MIN_V) val_d = val_q - 1'b1;
            CMD_PRESET: val_d = INIT_V;
            default:    val_d = val_q;
         endcase
      end
   end

   // Setpoint plus its change pulse and limit flag, all in step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         val_q <= INIT_V;
         chg_q <= 1'b0;
         lim_q <= INIT_LIM;
      end else begin
         val_q <= val_d;
         chg_q <= (val_d != val_q);
         lim_q <= (val_d == MIN_V) || (val_d == MAX_V);
      end
   end

   assign sp.value    = val_q;
   assign sp.changed  = chg_q;
   assign sp.at_limit = lim_q;
   assign sp.holding  = (state_q == REPEAT);

endmodule
